// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the fetch stage
// Purpose: fetch FSM state encoding, fetch FIFO entry layout, default reset vector.
// Ports: none (package).
package core_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of fetched instructions
// Purpose: buffers fetch_entry_t words between imem and decode.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr_i         drop all entries (wins over push/pop)
//   push_i        write wdata_i at tail (caller guarantees space)
//   wdata_i       entry to write
//   pop_i         retire head (caller guarantees non-empty)
//   head_o        current head entry (stale when count_o == 0)
//   count_o       number of valid entries
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: the head is only consumed while count_o != 0.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, imem request FSM and fetch FIFO
// Purpose: owns the PC, issues one imem read at a time, buffers words for decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   execute-stage PC load request
//   imem_req, imem_addr           read request toward instruction memory
//   imem_ack, imem_rdata          request accepted with data in the same cycle
//   inst_valid, inst_ready        handshake toward decode
//   inst_data, inst_pc, inst_fault  FIFO head contents (zero when empty)
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic          fault_pend_q, fault_pend_d;

  logic          fifo_clr, fifo_push, fifo_pop;
  fetch_entry_t  fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic          misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      drop_addr_q  <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    fault_pend_d = fault_pend_q;
    count_after  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      // A misaligned target becomes a single fault entry, pushed from HALT.
      fault_pend_d = misaligned;
      if (imem_req && !imem_ack) begin
        // The outstanding read must still complete; park its address.
        state_d = DROP;
        if (state_q == FETCH) drop_addr_d = pc_q;
      end else if (misaligned) begin
        state_d = HALT;
      end else if (imem_req) begin
        state_d = IDLE;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE:    if (fifo_count < DEPTH_C) state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_q + 32'd4;
            if (count_after >= DEPTH_C) state_d = IDLE;
          end
        end
        DROP:    if (imem_ack) state_d = fault_pend_q ? HALT : IDLE;
        HALT:    fault_pend_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = (state_q == FETCH) || (state_q == DROP);
    imem_addr  = (state_q == FETCH) ? pc_q :
                 (state_q == DROP)  ? drop_addr_q : 32'h0;
    inst_valid = (fifo_count != '0);
    fifo_clr   = redirect_valid;
    fifo_pop   = inst_valid && inst_ready && !redirect_valid;
    fifo_push  = !redirect_valid &&
                 (((state_q == FETCH) && imem_ack) || ((state_q == HALT) && fault_pend_q));
    if (state_q == HALT) fifo_wdata = '{pc: pc_q, inst: 32'h0, fault: 1'b1};
    else                 fifo_wdata = '{pc: pc_q, inst: imem_rdata, fault: 1'b0};
    inst_data  = inst_valid ? fifo_head.inst  : 32'h0;
    inst_pc    = inst_valid ? fifo_head.pc    : 32'h0;
    inst_fault = inst_valid ? fifo_head.fault : 1'b0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        ack_en;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic [31:0] seg_q[$];
  logic [31:0] exp_pc;
  int          exp_mode;
  logic        pend;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = memfn(imem_addr);

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference: decode sees consecutive words from the last redirect/reset
  // target; a misaligned target yields exactly one fault entry, then nothing.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc   = 32'h0;
      exp_mode = 0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        check("req_held", {31'b0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, pend_addr);
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (inst_valid && inst_ready) begin
        pops++;
        case (exp_mode)
          0: begin
            check("stream_pc", inst_pc, exp_pc);
            check("stream_data", inst_data, memfn(exp_pc));
            check("stream_fault", {31'b0, inst_fault}, 32'd0);
            exp_pc = exp_pc + 32'd4;
          end
          1: begin
            check("fault_pc", inst_pc, exp_pc);
            check("fault_data", inst_data, 32'h0);
            check("fault_flag", {31'b0, inst_fault}, 32'd1);
            exp_mode = 2;
          end
          default: check("extra_entry", {31'b0, inst_valid}, 32'd0);
        endcase
      end
      if (redirect_valid) begin
        check("seg_queue_nonempty", {31'b0, seg_q.size() != 0}, 32'd1);
        if (seg_q.size() != 0) begin
          exp_pc   = seg_q.pop_front();
          exp_mode = (exp_pc[1:0] != 2'b00) ? 1 : 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    seg_q.push_back(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input int max, input logic [31:0] addr, input string name);
    int n = 0;
    while (!imem_req && n < max) begin
      tick();
      n++;
    end
    check({name, "_req"}, {31'b0, imem_req}, 32'd1);
    if (imem_req) check({name, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] t;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    ack_en         = 1'b1;

    // 1: reset values, first-word latency, sequential stream
    do_reset();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_fault", {31'b0, inst_fault}, 32'd0);
    tick();
    check("t1_first_req", {31'b0, imem_req}, 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_early", {31'b0, inst_valid}, 32'd0);
    tick();
    check("t1_valid", {31'b0, inst_valid}, 32'd1);
    check("t1_pc", inst_pc, 32'h0);
    repeat (20) tick();

    // 2: backpressure fills exactly DEPTH entries, then fetch stops
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req && imem_ack) n++;
      tick();
    end
    check("t2_pushes", n, 32'd2);
    check("t2_req_off", {31'b0, imem_req}, 32'd0);
    check("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (20) tick();

    // 3: redirect while a request is pending, stale word dropped
    ack_en = 1'b0;
    do_reset();
    tick();
    do_redirect(32'h100);
    check("t3_drop_req", {31'b0, imem_req}, 32'd1);
    check("t3_drop_addr", imem_addr, 32'h0);
    tick();
    tick();
    ack_en = 1'b1;
    tick();
    wait_req(4, 32'h100, "t3_next");
    repeat (10) tick();

    // 4: redirect with ack and pop in the same cycle
    inst_ready = 1'b0;
    ack_en     = 1'b0;
    do_reset();
    tick();
    ack_en = 1'b1;
    tick();
    inst_ready = 1'b1;
    do_redirect(32'h200);
    check("t4_flushed", {31'b0, inst_valid}, 32'd0);
    wait_req(4, 32'h200, "t4_next");
    repeat (6) tick();

    // 5: misaligned redirect -> single fault entry, halt until redirect
    inst_ready = 1'b0;
    do_redirect(32'h102);
    n = 0;
    while (!inst_valid && n < 6) begin
      tick();
      n++;
    end
    check("t5_valid", {31'b0, inst_valid}, 32'd1);
    check("t5_fault", {31'b0, inst_fault}, 32'd1);
    check("t5_pc", inst_pc, 32'h102);
    check("t5_data", inst_data, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) n++;
      tick();
    end
    check("t5_no_req", n, 32'd0);
    inst_ready = 1'b1;
    tick();
    tick();
    check("t5_empty", {31'b0, inst_valid}, 32'd0);
    inst_ready = 1'b0;
    do_redirect(32'h40);
    check("t5_resume_req", {31'b0, imem_req}, 32'd1);
    check("t5_resume_addr", imem_addr, 32'h40);
    tick();
    check("t5_resume_valid", {31'b0, inst_valid}, 32'd1);
    check("t5_resume_pc", inst_pc, 32'h40);
    inst_ready = 1'b1;
    repeat (4) tick();

    // 6: PC wraps at the top of the address space; reset mid-fetch
    do_redirect(32'hFFFF_FFFC);
    wait_req(4, 32'hFFFF_FFFC, "t6_top");
    tick();
    check("t6_wrap_req", {31'b0, imem_req}, 32'd1);
    check("t6_wrap_addr", imem_addr, 32'h0);
    rst = 1'b1;
    tick();
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
    rst = 1'b0;
    wait_req(4, 32'h0, "t6_refetch");

    // Random traffic against the stream model
    for (int i = 0; i < 3000; i++) begin
      ack_en     = ($urandom % 3) != 0;
      inst_ready = ($urandom % 4) != 0;
      if (($urandom % 400) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (($urandom % 20) == 0) begin
        case ($urandom % 8)
          0:       t = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
          1:       t = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
          default: t = $urandom_range(0, 255) << 2;
        endcase
        do_redirect(t);
      end else begin
        tick();
      end
    end

    ack_en     = 1'b1;
    inst_ready = 1'b1;
    repeat (10) tick();
    check("seg_queue_drained", seg_q.size(), 32'd0);
    check("liveness", {31'b0, pops > 200}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
